// File: rtl/main_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : main_ctrl_pkg
// Purpose  : Shared types and encodings for the multicycle main control unit.
//            This package holds the state enum, the supported opcodes, the
//            ALUop/ALUSrcB/PCSource encodings (also used by the ALU control
//            decoder), the packed control vector and a legality helper.
// Config   : none (ILLEGAL_TRAP_EN is consumed by main_ctrl_fsm/outdec)
// Revision : 1.0 - initial release
// ============================================================================
package main_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST       = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_R    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12,
        S_TRAP      = 4'd13
    } state_t;

    // instruction[31:26]
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_addi  = 6'b001000;

    localparam logic [1:0] c_aluop_rtype = 2'b00;  // ALU control decodes funct
    localparam logic [1:0] c_aluop_add   = 2'b01;
    localparam logic [1:0] c_aluop_sub   = 2'b10;

    localparam logic [1:0] c_alusrcb_reg     = 2'b00;
    localparam logic [1:0] c_alusrcb_four    = 2'b01;
    localparam logic [1:0] c_alusrcb_imm     = 2'b10;
    localparam logic [1:0] c_alusrcb_imm_sh2 = 2'b11;

    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;

    typedef struct packed {
        logic       PCWrite;
        logic       PCWriteCond;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       MemtoReg;
        logic       IRWrite;
        logic       ALUSrcA;
        logic       RegWrite;
        logic       RegDst;
        logic [1:0] PCSource;
        logic [1:0] ALUSrcB;
        logic [1:0] ALUop;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        logic legal;
        case (op)
            c_op_rtype, c_op_lw, c_op_sw,
            c_op_beq, c_op_j, c_op_addi: legal = 1'b1;
            default:                     legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/main_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : main_ctrl_if
// Purpose  : Bundle between the main control unit and the datapath.
//            master : control unit (consumes opcode/mem_ready, drives controls)
//            slave  : datapath side (drives opcode/mem_ready, consumes controls)
// Signals  : opcode[5:0], mem_ready, PCWrite, PCWriteCond, IorD, MemRead,
//            MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst,
//            PCSource[1:0], ALUSrcB[1:0], ALUop[1:0], instr_done, illegal_op
// Revision : 1.0 - initial release
// ============================================================================
interface main_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;

    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic [1:0] PCSource;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUop;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUop,
               instr_done, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUop,
               instr_done, illegal_op
    );
endinterface
`default_nettype wire

// File: rtl/main_ctrl_outdec.sv
`default_nettype none
// ============================================================================
// Module   : main_ctrl_outdec
// Purpose  : Purely combinational state -> control vector decode (Moore).
//            The only input besides state is mem_ready, which gates the FETCH
//            IR/PC writes and the MEM_WRITE completion pulse.
// Ports    : state     in  state_t  current FSM state
//            mem_ready in  1        memory access completes this cycle
//            ctrl      out ctrl_t   every datapath control for this cycle
// Config   : ILLEGAL_TRAP_EN - decode the TRAP state (illegal_op=1)
// Revision : 1.0 - initial release
// ============================================================================
module main_ctrl_outdec
    import main_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.MemRead = 1'b1;
                ctrl.ALUSrcB = c_alusrcb_four;
                ctrl.ALUop   = c_aluop_add;
                // IR and PC only update on the cycle the instruction arrives
                ctrl.IRWrite = mem_ready;
                ctrl.PCWrite = mem_ready;
            end
            S_DECODE: begin
                ctrl.ALUSrcB = c_alusrcb_imm_sh2;  // speculative branch target
                ctrl.ALUop   = c_aluop_add;
            end
            S_MEM_ADDR: begin
                ctrl.ALUSrcA = 1'b1;
                ctrl.ALUSrcB = c_alusrcb_imm;
                ctrl.ALUop   = c_aluop_add;
            end
            S_MEM_READ: begin
                ctrl.MemRead = 1'b1;
                ctrl.IorD    = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.RegWrite   = 1'b1;
                ctrl.MemtoReg   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.MemWrite   = 1'b1;
                ctrl.IorD       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXEC_R: begin
                ctrl.ALUSrcA = 1'b1;
                ctrl.ALUSrcB = c_alusrcb_reg;
                ctrl.ALUop   = c_aluop_rtype;
            end
            S_R_WB: begin
                ctrl.RegWrite   = 1'b1;
                ctrl.RegDst     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.ALUSrcA     = 1'b1;
                ctrl.ALUop       = c_aluop_sub;
                ctrl.PCWriteCond = 1'b1;
                ctrl.PCSource    = c_pcsrc_aluout;
                ctrl.instr_done  = 1'b1;
            end
            S_JUMP: begin
                ctrl.PCWrite    = 1'b1;
                ctrl.PCSource   = c_pcsrc_jump;
                ctrl.instr_done = 1'b1;
            end
            S_ADDI_EXEC: begin
                ctrl.ALUSrcA = 1'b1;
                ctrl.ALUSrcB = c_alusrcb_imm;
                ctrl.ALUop   = c_aluop_add;
            end
            S_ADDI_WB: begin
                ctrl.RegWrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                ctrl.illegal_op = 1'b1;
            end
`endif
            default: ctrl = '0;  // S_RST and unused encodings
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/main_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : main_ctrl_fsm
// Purpose  : Multicycle main control unit. Moore FSM sequencing each
//            instruction through fetch/decode/execute/memory/write-back,
//            with memory wait states and unsupported-opcode handling.
// Ports    : clk   in  1  rising-edge clock
//            rst_n in  1  synchronous active-low reset
//            bus   main_ctrl_if.master  opcode/mem_ready in, controls out
// Config   : ILLEGAL_TRAP_EN - unsupported opcodes lock the FSM in TRAP
//            with illegal_op=1 until reset; otherwise they retire as a NOP
//            from DECODE and illegal_op is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module main_ctrl_fsm
    import main_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    main_ctrl_if.master    bus
);

    state_t r_state;
    state_t w_state_nxt;
    ctrl_t  w_ctrl;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RST:       w_state_nxt = S_FETCH;
            S_FETCH:     w_state_nxt = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    c_op_lw, c_op_sw: w_state_nxt = S_MEM_ADDR;
                    c_op_rtype:       w_state_nxt = S_EXEC_R;
                    c_op_beq:         w_state_nxt = S_BRANCH;
                    c_op_j:           w_state_nxt = S_JUMP;
                    c_op_addi:        w_state_nxt = S_ADDI_EXEC;
`ifdef ILLEGAL_TRAP_EN
                    default:          w_state_nxt = S_TRAP;
`else
                    default:          w_state_nxt = S_FETCH;
`endif
                endcase
            end
            // Anything that reached MEM_ADDR was lw or sw; treat non-sw as lw
            S_MEM_ADDR:  w_state_nxt = (bus.opcode == c_op_sw) ? S_MEM_WRITE
                                                               : S_MEM_READ;
            S_MEM_READ:  w_state_nxt = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    w_state_nxt = S_FETCH;
            S_MEM_WRITE: w_state_nxt = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXEC_R:    w_state_nxt = S_R_WB;
            S_R_WB:      w_state_nxt = S_FETCH;
            S_BRANCH:    w_state_nxt = S_FETCH;
            S_JUMP:      w_state_nxt = S_FETCH;
            S_ADDI_EXEC: w_state_nxt = S_ADDI_WB;
            S_ADDI_WB:   w_state_nxt = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:      w_state_nxt = S_TRAP;  // only reset leaves TRAP
`endif
            default:     w_state_nxt = S_RST;
        endcase
    end

    main_ctrl_outdec u_outdec (
        .state     (r_state),
        .mem_ready (bus.mem_ready),
        .ctrl      (w_ctrl)
    );

    assign bus.PCWrite     = w_ctrl.PCWrite;
    assign bus.PCWriteCond = w_ctrl.PCWriteCond;
    assign bus.IorD        = w_ctrl.IorD;
    assign bus.MemRead     = w_ctrl.MemRead;
    assign bus.MemWrite    = w_ctrl.MemWrite;
    assign bus.MemtoReg    = w_ctrl.MemtoReg;
    assign bus.IRWrite     = w_ctrl.IRWrite;
    assign bus.ALUSrcA     = w_ctrl.ALUSrcA;
    assign bus.RegWrite    = w_ctrl.RegWrite;
    assign bus.RegDst      = w_ctrl.RegDst;
    assign bus.PCSource    = w_ctrl.PCSource;
    assign bus.ALUSrcB     = w_ctrl.ALUSrcB;
    assign bus.ALUop       = w_ctrl.ALUop;
    assign bus.illegal_op  = w_ctrl.illegal_op;

`ifdef ILLEGAL_TRAP_EN
    assign bus.instr_done  = w_ctrl.instr_done;
`else
    // An unsupported opcode retires as a NOP directly out of DECODE
    assign bus.instr_done  = w_ctrl.instr_done |
                             ((r_state == S_DECODE) && !is_legal_op(bus.opcode));
`endif

endmodule
`default_nettype wire

// File: tb/tb_main_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_ctrl_fsm
// Purpose  : Self-checking bench for main_ctrl_fsm. Each driven cycle pushes
//            the expected control vector for that cycle onto a scoreboard;
//            a negedge monitor pops and compares against the DUT outputs.
// Config   : ILLEGAL_TRAP_EN - selects the expected illegal-opcode behaviour
// Revision : 1.0 - initial release
// ============================================================================
module tb_main_ctrl_fsm;

    localparam logic [5:0] c_r    = 6'b000000;
    localparam logic [5:0] c_lw   = 6'b100011;
    localparam logic [5:0] c_sw   = 6'b101011;
    localparam logic [5:0] c_beq  = 6'b000100;
    localparam logic [5:0] c_j    = 6'b000010;
    localparam logic [5:0] c_addi = 6'b001000;
    localparam logic [5:0] c_bad  = 6'b111111;

    // bench-side state labels
    localparam int T_RST = 0, T_FETCH = 1, T_DECODE = 2, T_MEM_ADDR = 3,
                   T_MEM_READ = 4, T_MEM_WB = 5, T_MEM_WRITE = 6,
                   T_EXEC_R = 7, T_R_WB = 8, T_BRANCH = 9, T_JUMP = 10,
                   T_ADDI_EXEC = 11, T_ADDI_WB = 12, T_TRAP = 13,
                   T_DECODE_NOP = 14;

    typedef struct {
        string       tag;
        logic [17:0] v;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n;
    exp_t  sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    main_ctrl_if bus ();

    main_ctrl_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    wire [17:0] w_obs = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                         bus.MemWrite, bus.MemtoReg, bus.IRWrite, bus.ALUSrcA,
                         bus.RegWrite, bus.RegDst, bus.PCSource, bus.ALUSrcB,
                         bus.ALUop, bus.instr_done, bus.illegal_op};

    // Expected outputs straight from the per-state control table
    function automatic logic [17:0] exp_vec(input int st, input logic rdy);
        logic       pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rdst;
        logic [1:0] pcs, srcb, aop;
        logic       done, ill;
        {pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rdst} = '0;
        pcs = 2'b00; srcb = 2'b00; aop = 2'b00; done = 1'b0; ill = 1'b0;
        case (st)
            T_FETCH:      begin mrd = 1; srcb = 2'b01; aop = 2'b01; irw = rdy; pcw = rdy; end
            T_DECODE:     begin srcb = 2'b11; aop = 2'b01; end
            T_DECODE_NOP: begin srcb = 2'b11; aop = 2'b01; done = 1; end
            T_MEM_ADDR:   begin srca = 1; srcb = 2'b10; aop = 2'b01; end
            T_MEM_READ:   begin mrd = 1; iord = 1; end
            T_MEM_WB:     begin rw = 1; m2r = 1; done = 1; end
            T_MEM_WRITE:  begin mwr = 1; iord = 1; done = rdy; end
            T_EXEC_R:     begin srca = 1; end
            T_R_WB:       begin rw = 1; rdst = 1; done = 1; end
            T_BRANCH:     begin srca = 1; aop = 2'b10; pcwc = 1; pcs = 2'b01; done = 1; end
            T_JUMP:       begin pcw = 1; pcs = 2'b10; done = 1; end
            T_ADDI_EXEC:  begin srca = 1; srcb = 2'b10; aop = 2'b01; end
            T_ADDI_WB:    begin rw = 1; done = 1; end
            T_TRAP:       begin ill = 1; end
            default:      ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rdst,
                pcs, srcb, aop, done, ill};
    endfunction

    task automatic check_eq(input string tag, input logic [17:0] obs,
                            input logic [17:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_eq(e.tag, w_obs, e.v);
        end
    end

    // Drive one cycle's inputs (rn takes effect at the coming edge) and
    // queue the outputs expected while in state st during this cycle.
    task automatic step(input int st, input logic [5:0] op, input logic rdy,
                        input logic rn, input string tag);
        exp_t e;
        bus.opcode    = op;
        bus.mem_ready = rdy;
        rst_n         = rn;
        e.tag = tag;
        e.v   = exp_vec(st, rdy);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.opcode    = c_r;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        step(T_RST, c_r, 1'b1, 1'b1, "reset_state");

        // lw: 5 cycles
        step(T_FETCH,    c_lw, 1'b1, 1'b1, "lw_fetch");
        step(T_DECODE,   c_lw, 1'b1, 1'b1, "lw_decode");
        step(T_MEM_ADDR, c_lw, 1'b1, 1'b1, "lw_mem_addr");
        step(T_MEM_READ, c_lw, 1'b1, 1'b1, "lw_mem_read");
        step(T_MEM_WB,   c_lw, 1'b1, 1'b1, "lw_mem_wb");

        // R-type (4) then beq (3)
        step(T_FETCH,  c_r,   1'b1, 1'b1, "r_fetch");
        step(T_DECODE, c_r,   1'b1, 1'b1, "r_decode");
        step(T_EXEC_R, c_r,   1'b1, 1'b1, "r_exec");
        step(T_R_WB,   c_r,   1'b1, 1'b1, "r_wb");
        step(T_FETCH,  c_beq, 1'b1, 1'b1, "beq_fetch");
        step(T_DECODE, c_beq, 1'b1, 1'b1, "beq_decode");
        step(T_BRANCH, c_beq, 1'b1, 1'b1, "beq_branch");

        // sw with 3 fetch waits and 2 write waits: 9 cycles
        step(T_FETCH,     c_sw, 1'b0, 1'b1, "sw_fetch_wait0");
        step(T_FETCH,     c_sw, 1'b0, 1'b1, "sw_fetch_wait1");
        step(T_FETCH,     c_sw, 1'b0, 1'b1, "sw_fetch_wait2");
        step(T_FETCH,     c_sw, 1'b1, 1'b1, "sw_fetch_ready");
        step(T_DECODE,    c_sw, 1'b1, 1'b1, "sw_decode");
        step(T_MEM_ADDR,  c_sw, 1'b1, 1'b1, "sw_mem_addr");
        step(T_MEM_WRITE, c_sw, 1'b0, 1'b1, "sw_write_wait0");
        step(T_MEM_WRITE, c_sw, 1'b0, 1'b1, "sw_write_wait1");
        step(T_MEM_WRITE, c_sw, 1'b1, 1'b1, "sw_write_ready");

        // j (3) and addi (4)
        step(T_FETCH,     c_j,    1'b1, 1'b1, "j_fetch");
        step(T_DECODE,    c_j,    1'b1, 1'b1, "j_decode");
        step(T_JUMP,      c_j,    1'b1, 1'b1, "j_jump");
        step(T_FETCH,     c_addi, 1'b1, 1'b1, "addi_fetch");
        step(T_DECODE,    c_addi, 1'b1, 1'b1, "addi_decode");
        step(T_ADDI_EXEC, c_addi, 1'b1, 1'b1, "addi_exec");
        step(T_ADDI_WB,   c_addi, 1'b1, 1'b1, "addi_wb");

        // reset in the middle of a stalled store
        step(T_FETCH,     c_sw, 1'b1, 1'b1, "rsw_fetch");
        step(T_DECODE,    c_sw, 1'b1, 1'b1, "rsw_decode");
        step(T_MEM_ADDR,  c_sw, 1'b1, 1'b1, "rsw_mem_addr");
        step(T_MEM_WRITE, c_sw, 1'b0, 1'b0, "rsw_write_rst");
        step(T_RST,       c_sw, 1'b0, 1'b1, "rsw_in_reset");
        step(T_FETCH,     c_sw, 1'b1, 1'b1, "rsw_refetch");
        step(T_DECODE,    c_sw, 1'b1, 1'b1, "rsw_redecode");
        step(T_MEM_ADDR,  c_sw, 1'b1, 1'b1, "rsw_mem_addr2");
        step(T_MEM_WRITE, c_sw, 1'b1, 1'b1, "rsw_write_done");

        // unsupported opcode
        step(T_FETCH, c_bad, 1'b1, 1'b1, "bad_fetch");
`ifdef ILLEGAL_TRAP_EN
        step(T_DECODE, c_bad, 1'b1, 1'b1, "bad_decode");
        step(T_TRAP,   c_lw,  1'b1, 1'b1, "trap_hold0");
        step(T_TRAP,   c_lw,  1'b0, 1'b1, "trap_hold1");
        step(T_TRAP,   c_lw,  1'b1, 1'b0, "trap_rst");
        step(T_RST,    c_lw,  1'b1, 1'b1, "trap_in_reset");
        step(T_FETCH,  c_lw,  1'b1, 1'b1, "trap_refetch");
`else
        step(T_DECODE_NOP, c_bad, 1'b1, 1'b1, "nop_decode");
        step(T_FETCH,      c_j,   1'b1, 1'b1, "nop_next_fetch");
        step(T_DECODE,     c_j,   1'b1, 1'b1, "nop_next_decode");
        step(T_JUMP,       c_j,   1'b1, 1'b1, "nop_next_jump");
`endif

        check_eq("scoreboard_drained", 18'(sb.size()), 18'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
